// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend memory retire logic.
// Holds the retire FSM state type and the RISC-V mcause codes for memory faults.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_idle      = 2'd0,
    e_tlb_wait  = 2'd1,
    e_miss_wait = 2'd2,
    e_replay    = 2'd3
  } bp_be_mem_retire_state_e;

  localparam logic [3:0] store_misaligned_cause_c = 4'd6;
  localparam logic [3:0] load_misaligned_cause_c  = 4'd4;
  localparam logic [3:0] store_page_cause_c       = 4'd15;
  localparam logic [3:0] load_page_cause_c        = 4'd13;
  localparam logic [3:0] store_access_cause_c     = 4'd7;
  localparam logic [3:0] load_access_cause_c      = 4'd5;

endpackage

// File: rtl/bp_be_mem_exc_encode.sv
// Priority encoder turning the mem3 fault vector into an mcause code.
// Fault bits are {store_misaligned, load_misaligned, store_page, load_page,
// store_access, load_access}; the MSB has the highest priority.
module bp_be_mem_exc_encode
  import bp_be_pkg::*;
 (input  logic [5:0] fault
  , output logic [3:0] cause
  );

  // Pick the highest-priority fault; zero when no fault is present
  always_comb begin
    cause = 4'd0;
    if (fault[5])      cause = store_misaligned_cause_c;
    else if (fault[4]) cause = load_misaligned_cause_c;
    else if (fault[3]) cause = store_page_cause_c;
    else if (fault[2]) cause = load_page_cause_c;
    else if (fault[1]) cause = store_access_cause_c;
    else if (fault[0]) cause = load_access_cause_c;
  end

endmodule

// File: rtl/bp_be_mem_retire.sv
// Retire stage for memory instructions leaving mem3.
// Completes loads, raises exceptions, and parks TLB / D$ misses until they are
// serviced, then requests a replay of the missing instruction from the front end.
// Optional miss-cycle statistics counter: define BP_BE_MEM_RETIRE_STATS_EN.
module bp_be_mem_retire
  import bp_be_pkg::*;
 #(parameter int vaddr_width_p    = 39
  , parameter int dword_width_p    = 64
  , parameter int miss_cnt_width_p = 16
  )
 (input  logic                        clk_i
  , input  logic                        reset_i
  , input  logic                        v_i
  , input  logic                        kill_i
  , input  logic                        flush_i
  , input  logic [vaddr_width_p-1:0]    pc_i
  , input  logic [vaddr_width_p-1:0]    vaddr_i
  , input  logic [dword_width_p-1:0]    data_i
  , input  logic                        tlb_miss_v_i
  , input  logic                        cache_miss_v_i
  , input  logic                        fencei_v_i
  , input  logic [5:0]                  fault_i
  , input  logic                        ptw_fill_v_i
  , input  logic                        cache_req_complete_i
  , input  logic                        replay_ready_i
  , output logic                        wb_v_o
  , output logic [dword_width_p-1:0]    wb_data_o
  , output logic                        exc_v_o
  , output logic [3:0]                  exc_cause_o
  , output logic [vaddr_width_p-1:0]    exc_tval_o
  , output logic [vaddr_width_p-1:0]    exc_pc_o
  , output logic                        replay_v_o
  , output logic [vaddr_width_p-1:0]    replay_pc_o
  , output logic                        stall_o
  , output logic [miss_cnt_width_p-1:0] miss_cycles_o
  );

  bp_be_mem_retire_state_e state_r, state_n;
  logic [vaddr_width_p-1:0] replay_pc_r;
  logic [3:0] cause_n;
  logic accept, fault_v, miss_capture, wb_n, exc_n;

  // A fence.i retires like an ordinary load, so it needs no dedicated path
  logic unused_fencei;
  assign unused_fencei = fencei_v_i;

  assign accept       = (state_r == e_idle) & v_i & ~kill_i & ~flush_i;
  assign fault_v      = |fault_i;
  assign miss_capture = accept & ~fault_v & (tlb_miss_v_i | cache_miss_v_i);
  assign wb_n         = accept & ~fault_v & ~tlb_miss_v_i & ~cache_miss_v_i;
  assign exc_n        = accept & fault_v;

  bp_be_mem_exc_encode exc_encode
   (.fault (fault_i)
    ,.cause (cause_n)
    );

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state_r <= e_idle;
    else          state_r <= state_n;
  end

  // Next-state logic; a flush overrides every completion and handshake
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:      if (miss_capture) state_n = tlb_miss_v_i ? e_tlb_wait : e_miss_wait;
      e_tlb_wait:  if (ptw_fill_v_i) state_n = e_replay;
      e_miss_wait: if (cache_req_complete_i) state_n = e_replay;
      e_replay:    if (replay_ready_i) state_n = e_idle;
      default:     state_n = e_idle;
    endcase
    if (flush_i) state_n = e_idle;
  end

  // Capture the PC of a missing instruction so it can be replayed later
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)          replay_pc_r <= '0;
    else if (miss_capture) replay_pc_r <= pc_i;
  end

  // Registered writeback and exception pulses with their payloads
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wb_v_o      <= 1'b0;
      wb_data_o   <= '0;
      exc_v_o     <= 1'b0;
      exc_cause_o <= 4'd0;
      exc_tval_o  <= '0;
      exc_pc_o    <= '0;
    end else begin
      wb_v_o  <= wb_n;
      exc_v_o <= exc_n;
      if (wb_n) wb_data_o <= data_i;
      if (exc_n) begin
        exc_cause_o <= cause_n;
        exc_tval_o  <= vaddr_i;
        exc_pc_o    <= pc_i;
      end
    end
  end

  assign replay_v_o  = (state_r == e_replay);
  assign replay_pc_o = replay_pc_r;
  assign stall_o     = (state_r != e_idle);

`ifdef BP_BE_MEM_RETIRE_STATS_EN
  logic [miss_cnt_width_p-1:0] miss_cycles_r;

  // Saturating count of cycles spent waiting on a TLB fill or D$ miss
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) miss_cycles_r <= '0;
    else if (((state_r == e_tlb_wait) || (state_r == e_miss_wait)) && !(&miss_cycles_r))
      miss_cycles_r <= miss_cycles_r + miss_cnt_width_p'(1);
  end

  assign miss_cycles_o = miss_cycles_r;
`else
  assign miss_cycles_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_mem_retire.sv
// Self-checking bench for bp_be_mem_retire with directed scenarios and a
// randomized run compared against a transaction-level reference model.
module tb_bp_be_mem_retire;

  localparam int va_w = 39;
  localparam int dw_w = 64;
  localparam int mc_w = 16;

`ifdef BP_BE_MEM_RETIRE_STATS_EN
  localparam bit stats_en = 1'b1;
`else
  localparam bit stats_en = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic v_i, kill_i, flush_i;
  logic [va_w-1:0] pc_i, vaddr_i;
  logic [dw_w-1:0] data_i;
  logic tlb_miss_v_i, cache_miss_v_i, fencei_v_i;
  logic [5:0] fault_i;
  logic ptw_fill_v_i, cache_req_complete_i, replay_ready_i;
  logic wb_v_o, exc_v_o, replay_v_o, stall_o;
  logic [dw_w-1:0] wb_data_o;
  logic [3:0] exc_cause_o;
  logic [va_w-1:0] exc_tval_o, exc_pc_o, replay_pc_o;
  logic [mc_w-1:0] miss_cycles_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: outstanding-miss status 0 none, 1 awaiting PTW fill,
  // 2 awaiting D$ refill, 3 offering replay to the front end
  int m_status;
  logic m_wb_v, m_exc_v;
  logic [dw_w-1:0] m_wb_data;
  logic [3:0] m_cause;
  logic [va_w-1:0] m_tval, m_epc, m_pc;
  longint m_miss;

  bp_be_mem_retire #(.vaddr_width_p(va_w), .dword_width_p(dw_w), .miss_cnt_width_p(mc_w)) dut
   (.clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .kill_i(kill_i), .flush_i(flush_i)
    ,.pc_i(pc_i), .vaddr_i(vaddr_i), .data_i(data_i)
    ,.tlb_miss_v_i(tlb_miss_v_i), .cache_miss_v_i(cache_miss_v_i), .fencei_v_i(fencei_v_i)
    ,.fault_i(fault_i), .ptw_fill_v_i(ptw_fill_v_i), .cache_req_complete_i(cache_req_complete_i)
    ,.replay_ready_i(replay_ready_i), .wb_v_o(wb_v_o), .wb_data_o(wb_data_o)
    ,.exc_v_o(exc_v_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o), .exc_pc_o(exc_pc_o)
    ,.replay_v_o(replay_v_o), .replay_pc_o(replay_pc_o), .stall_o(stall_o)
    ,.miss_cycles_o(miss_cycles_o));

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] ref_cause(input logic [5:0] f);
    logic [3:0] code_by_bit [6];
    code_by_bit = '{4'd5, 4'd7, 4'd13, 4'd15, 4'd4, 4'd6};
    for (int i = 5; i >= 0; i--) if (f[i]) return code_by_bit[i];
    return 4'd0;
  endfunction

  task automatic model_reset();
    m_status = 0; m_wb_v = 0; m_exc_v = 0; m_wb_data = '0;
    m_cause = '0; m_tval = '0; m_epc = '0; m_pc = '0; m_miss = 0;
  endtask

  task automatic model_clock();
    bit acc, clean;
    acc   = (m_status == 0) && v_i && !kill_i && !flush_i;
    clean = acc && (fault_i == 6'd0);
    m_wb_v  = clean && !tlb_miss_v_i && !cache_miss_v_i;
    m_exc_v = acc && (fault_i != 6'd0);
    if (m_wb_v) m_wb_data = data_i;
    if (m_exc_v) begin m_cause = ref_cause(fault_i); m_tval = vaddr_i; m_epc = pc_i; end
    if (stats_en && (m_status == 1 || m_status == 2) && m_miss < (64'd1 << mc_w) - 1) m_miss++;
    if (flush_i) m_status = 0;
    else if (m_status == 0) begin
      if (clean && tlb_miss_v_i) begin m_status = 1; m_pc = pc_i; end
      else if (clean && cache_miss_v_i) begin m_status = 2; m_pc = pc_i; end
    end
    else if (m_status == 1 && ptw_fill_v_i) m_status = 3;
    else if (m_status == 2 && cache_req_complete_i) m_status = 3;
    else if (m_status == 3 && replay_ready_i) m_status = 0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    v_i = 0; kill_i = 0; flush_i = 0; pc_i = '0; vaddr_i = '0; data_i = '0;
    tlb_miss_v_i = 0; cache_miss_v_i = 0; fencei_v_i = 0; fault_i = '0;
    ptw_fill_v_i = 0; cache_req_complete_i = 0; replay_ready_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    v_i = 1; data_i = 64'h1234; tlb_miss_v_i = 1;
    model_reset();
    #2;
    vectors++;
    if ({wb_v_o, exc_v_o, replay_v_o, stall_o} !== 4'b0) begin
      miscompares++; $display("[TB] FAIL reset_flags: got %b expected 0000", {wb_v_o, exc_v_o, replay_v_o, stall_o});
    end
    vectors++;
    if ({wb_data_o, exc_cause_o, exc_tval_o, exc_pc_o, replay_pc_o, miss_cycles_o} !== '0) begin
      miscompares++; $display("[TB] FAIL reset_data: got %h expected 0", {wb_data_o, exc_cause_o, exc_tval_o, exc_pc_o});
    end
    @(posedge clk_i); #1;
    vectors++;
    if ({wb_v_o, stall_o} !== 2'b0) begin
      miscompares++; $display("[TB] FAIL reset_held: got %b expected 00", {wb_v_o, stall_o});
    end
    reset_i = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_load();
    idle_inputs();
    v_i = 1; data_i = 64'hDEAD_BEEF; pc_i = 39'h100; fencei_v_i = 0;
    tick();
    vectors++;
    if (wb_v_o !== 1'b1 || wb_data_o !== 64'hDEAD_BEEF) begin
      miscompares++; $display("[TB] FAIL load_wb: got v=%b d=%h expected v=1 d=deadbeef", wb_v_o, wb_data_o);
    end
    vectors++;
    if (exc_v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_noexc: got exc=%b stall=%b expected 0 0", exc_v_o, stall_o);
    end
    idle_inputs();
    tick();
    vectors++;
    if (wb_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL load_pulse: got %b expected 0", wb_v_o);
    end
    v_i = 1; fencei_v_i = 1; data_i = 64'h55;
    tick();
    vectors++;
    if (wb_v_o !== 1'b1 || wb_data_o !== 64'h55) begin
      miscompares++; $display("[TB] FAIL fencei_wb: got v=%b d=%h expected v=1 d=55", wb_v_o, wb_data_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fault();
    idle_inputs();
    v_i = 1; fault_i = 6'b001100; vaddr_i = 39'h1000; pc_i = 39'h2468;
    tlb_miss_v_i = 1; cache_miss_v_i = 1;
    tick();
    vectors++;
    if (exc_v_o !== 1'b1 || exc_cause_o !== 4'd15) begin
      miscompares++; $display("[TB] FAIL fault_cause: got v=%b c=%0d expected v=1 c=15", exc_v_o, exc_cause_o);
    end
    vectors++;
    if (exc_tval_o !== 39'h1000 || exc_pc_o !== 39'h2468) begin
      miscompares++; $display("[TB] FAIL fault_addr: got tval=%h pc=%h expected 1000 2468", exc_tval_o, exc_pc_o);
    end
    vectors++;
    if (wb_v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fault_nowb: got wb=%b stall=%b expected 0 0", wb_v_o, stall_o);
    end
    idle_inputs();
    tick();
    vectors++;
    if (exc_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fault_pulse: got %b expected 0", exc_v_o);
    end
  endtask

  task automatic test_fault_priority();
    for (int n = 0; n < 24; n++) begin
      idle_inputs();
      v_i = 1; fault_i = 6'($urandom_range(1, 63)); vaddr_i = va_w'({$urandom, $urandom});
      tick();
      vectors++;
      if (exc_v_o !== 1'b1 || exc_cause_o !== m_cause) begin
        miscompares++; $display("[TB] FAIL prio_cause f=%b: got v=%b c=%0d expected v=1 c=%0d", fault_i, exc_v_o, exc_cause_o, m_cause);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_tlb_replay();
    idle_inputs();
    v_i = 1; tlb_miss_v_i = 1; cache_miss_v_i = 1; pc_i = 39'h80000040;
    tick();
    idle_inputs();
    v_i = 1; data_i = 64'hABCD;
    vectors++;
    if (stall_o !== 1'b1 || replay_v_o !== 1'b0 || wb_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL tlb_enter: got stall=%b rp=%b wb=%b expected 1 0 0", stall_o, replay_v_o, wb_v_o);
    end
    for (int i = 0; i < 5; i++) tick();
    vectors++;
    if (stall_o !== 1'b1 || wb_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL tlb_wait: got stall=%b wb=%b expected 1 0", stall_o, wb_v_o);
    end
    v_i = 0; ptw_fill_v_i = 1;
    tick();
    ptw_fill_v_i = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (replay_v_o !== 1'b1 || replay_pc_o !== 39'h80000040) begin
        miscompares++; $display("[TB] FAIL tlb_replay cyc%0d: got v=%b pc=%h expected v=1 pc=80000040", i, replay_v_o, replay_pc_o);
      end
      if (i < 3) tick();
    end
    replay_ready_i = 1;
    tick();
    replay_ready_i = 0;
    vectors++;
    if (replay_v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL tlb_done: got rp=%b stall=%b expected 0 0", replay_v_o, stall_o);
    end
    vectors++;
    if (miss_cycles_o !== mc_w'(m_miss)) begin
      miscompares++; $display("[TB] FAIL tlb_misscnt: got %0d expected %0d", miss_cycles_o, m_miss);
    end
  endtask

  task automatic test_flush_complete();
    idle_inputs();
    v_i = 1; cache_miss_v_i = 1; pc_i = va_w'({$urandom, $urandom});
    tick();
    idle_inputs();
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++; $display("[TB] FAIL miss_enter: got %b expected 1", stall_o);
    end
    tick(); tick();
    flush_i = 1; cache_req_complete_i = 1;
    tick();
    idle_inputs();
    vectors++;
    if (stall_o !== 1'b0 || replay_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_complete: got stall=%b rp=%b expected 0 0", stall_o, replay_v_o);
    end
    tick();
    vectors++;
    if (replay_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_noreplay: got %b expected 0", replay_v_o);
    end
    v_i = 1; cache_miss_v_i = 1; pc_i = 39'h77;
    tick();
    idle_inputs(); cache_req_complete_i = 1;
    tick();
    idle_inputs();
    vectors++;
    if (replay_v_o !== 1'b1 || replay_pc_o !== 39'h77) begin
      miscompares++; $display("[TB] FAIL miss_replay: got v=%b pc=%h expected v=1 pc=77", replay_v_o, replay_pc_o);
    end
    flush_i = 1; replay_ready_i = 1;
    tick();
    idle_inputs();
    vectors++;
    if (replay_v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL replay_flush: got rp=%b stall=%b expected 0 0", replay_v_o, stall_o);
    end
  endtask

  task automatic test_kill();
    idle_inputs();
    v_i = 1; kill_i = 1; data_i = 64'h99; fault_i = 6'b1;
    tick();
    vectors++;
    if (wb_v_o !== 1'b0 || exc_v_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL kill_drop: got wb=%b exc=%b expected 0 0", wb_v_o, exc_v_o);
    end
    kill_i = 0; fault_i = '0; flush_i = 1; tlb_miss_v_i = 1;
    tick();
    vectors++;
    if (wb_v_o !== 1'b0 || stall_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_drop: got wb=%b stall=%b expected 0 0", wb_v_o, stall_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    #2; reset_i = 0; model_reset();
    #2; reset_i = 1;
    @(posedge clk_i); #1;
    v_i = 1; cache_miss_v_i = 1; pc_i = 39'h4_0000_1230;
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) tick();
    vectors++;
    if (miss_cycles_o !== (stats_en ? mc_w'(10) : mc_w'(0))) begin
      miscompares++; $display("[TB] FAIL miss_cycles10: got %0d expected %0d", miss_cycles_o, stats_en ? 10 : 0);
    end
    vectors++;
    if (stall_o !== 1'b1 || replay_pc_o !== 39'h4_0000_1230) begin
      miscompares++; $display("[TB] FAIL miss_hold: got stall=%b pc=%h expected 1 400001230", stall_o, replay_pc_o);
    end
    cache_req_complete_i = 1;
    #2; reset_i = 0;
    #1;
    vectors++;
    if ({stall_o, replay_v_o, wb_v_o, exc_v_o, replay_pc_o, miss_cycles_o} !== '0) begin
      miscompares++; $display("[TB] FAIL async_reset: got stall=%b rp=%b pc=%h cnt=%0d expected all 0", stall_o, replay_v_o, replay_pc_o, miss_cycles_o);
    end
    model_reset();
    @(posedge clk_i); #1;
    reset_i = 1;
    idle_inputs();
    tick();
    vectors++;
    if (replay_v_o !== 1'b0 || stall_o !== 1'b0 || replay_pc_o !== '0) begin
      miscompares++; $display("[TB] FAIL post_reset: got rp=%b stall=%b pc=%h expected 0 0 0", replay_v_o, stall_o, replay_pc_o);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      v_i = ($urandom_range(0, 99) < 60);
      kill_i = ($urandom_range(0, 99) < 10);
      flush_i = ($urandom_range(0, 99) < 5);
      pc_i = va_w'({$urandom, $urandom});
      vaddr_i = va_w'({$urandom, $urandom});
      data_i = {$urandom, $urandom};
      tlb_miss_v_i = ($urandom_range(0, 99) < 15);
      cache_miss_v_i = ($urandom_range(0, 99) < 20);
      fencei_v_i = ($urandom_range(0, 99) < 10);
      fault_i = ($urandom_range(0, 99) < 20) ? 6'($urandom) : 6'd0;
      ptw_fill_v_i = ($urandom_range(0, 99) < 30);
      cache_req_complete_i = ($urandom_range(0, 99) < 30);
      replay_ready_i = ($urandom_range(0, 99) < 50);
      tick();
      vectors++;
      if (wb_v_o !== m_wb_v || exc_v_o !== m_exc_v || replay_v_o !== (m_status == 3) || stall_o !== (m_status != 0)) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl cyc%0d: got wb=%b exc=%b rp=%b st=%b expected %b %b %b %b", n,
                 wb_v_o, exc_v_o, replay_v_o, stall_o, m_wb_v, m_exc_v, m_status == 3, m_status != 0);
      end
      vectors++;
      if ((m_wb_v && wb_data_o !== m_wb_data) ||
          (m_exc_v && {exc_cause_o, exc_tval_o, exc_pc_o} !== {m_cause, m_tval, m_epc}) ||
          (m_status == 3 && replay_pc_o !== m_pc) || miss_cycles_o !== mc_w'(m_miss)) begin
        miscompares++;
        $display("[TB] FAIL rand_data cyc%0d: got d=%h c=%0d pc=%h cnt=%0d expected d=%h c=%0d pc=%h cnt=%0d", n,
                 wb_data_o, exc_cause_o, replay_pc_o, miss_cycles_o, m_wb_data, m_cause, m_pc, m_miss);
      end
    end
    idle_inputs();
    flush_i = 1;
    tick();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load();
    test_fault();
    test_fault_priority();
    test_tlb_replay();
    test_flush_complete();
    test_kill();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
